data_ram_arbiter: RTL and testbench

Two-master arbiter that shares the single-port `data_ram` between the CPU data-memory port (M0) and a loader/DMA port (M1). It sits between `cpu`/loader and `data_ram` inside the SOPC top. It is parked on the CPU for zero-latency loads/stores, and stalls whichever master is not granted. Bounded wait and hold counters prevent either master from starving the other.

---
 rtl/data_ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the single-port data RAM between the CPU data port
// (M0) and the loader/DMA port (M1). Ownership is parked on M0; M1 gets in
// when M0 is idle or after a bounded number of denials, and a locked M1 burst
// is cut short after a bounded hold while M0 is waiting.
module data_ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_stall,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_sel,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_stall,
  input  logic              m1_lock,

  output logic              ram_ce,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  typedef enum logic {
    G0 = 1'b0,
    G1 = 1'b1
  } owner_t;

  // Last counter value before the forced handover (compare happens before
  // the increment, so MAX_WAIT denials / MAX_HOLD holds are allowed).
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  owner_t     owner;
  owner_t     owner_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic [3:0] hold_cnt;
  logic [3:0] hold_nxt;

  // Owner and fairness counters; synchronous active-low reset parks on M0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner    <= G0;
      wait_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      owner    <= owner_nxt;
      wait_cnt <= wait_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next owner and counter values; any owner change clears both counters.
  always_comb begin
    owner_nxt = owner;
    wait_nxt  = wait_cnt;
    hold_nxt  = hold_cnt;
    case (owner)
      G0: begin
        hold_nxt = '0;
        if (m1_req && !m0_req) begin
          owner_nxt = G1;
          wait_nxt  = '0;
        end else if (m1_req) begin
          // M1 denied again: force it in once the wait budget is spent.
          if (wait_cnt == WAIT_LAST) begin
            owner_nxt = G1;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_cnt + 4'd1;
          end
        end else begin
          wait_nxt = '0;
        end
      end
      G1: begin
        wait_nxt = '0;
        if (!m1_req) begin
          owner_nxt = G0;
          hold_nxt  = '0;
        end else if (m0_req && !m1_lock) begin
          // Unlocked M1 yields to a waiting CPU right away.
          owner_nxt = G0;
          hold_nxt  = '0;
        end else if (m0_req) begin
          // Locked burst while the CPU waits: override the lock at the limit.
          if (hold_cnt == HOLD_LAST) begin
            owner_nxt = G0;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + 4'd1;
          end
        end
      end
      default: begin
        owner_nxt = G0;
        wait_nxt  = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  // RAM port mux, acks, read-data return and stalls; all forced low in reset
  // so an access in flight when reset hits never writes the RAM.
  always_comb begin
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_sel    = '0;
    ram_addr   = '0;
    ram_data_o = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_stall   = 1'b0;
    m1_stall   = 1'b0;
    if (rst) begin
      if (owner == G1) begin
        m1_ack = m1_req;
        if (m1_req) begin
          ram_ce     = 1'b1;
          ram_we     = m1_we;
          ram_sel    = m1_sel;
          ram_addr   = m1_addr;
          ram_data_o = m1_wdata;
        end
      end else begin
        m0_ack = m0_req;
        if (m0_req) begin
          ram_ce     = 1'b1;
          ram_we     = m0_we;
          ram_sel    = m0_sel;
          ram_addr   = m0_addr;
          ram_data_o = m0_wdata;
        end
      end
      m0_rdata = m0_ack ? ram_data_i : '0;
      m1_rdata = m1_ack ? ram_data_i : '0;
      m0_stall = m0_req & ~m0_ack;
      m1_stall = m1_req & ~m1_ack;
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed scenarios plus randomized traffic, with a
// word-addressed RAM stand-in and a reference model of ownership and memory.
module tb_data_ram_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_stall, m1_ack, m1_stall;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_data_o, ram_data_i;

  data_ram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .m1_lock(m1_lock),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stand-in: combinational read, byte-selected write on the clock edge.
  logic [31:0] mem [64];
  logic        mem_ready = 1'b0;
  assign ram_data_i = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem_ready <= 1'b1;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  int m_own, m_wait, m_hold;
  bit pend0, pend1;
  int n_checks, n_err;

  // Last sampled DUT outputs for scenario-level checks.
  logic        s_m0_ack, s_m1_ack, s_m0_stall, s_m1_stall;
  logic [31:0] s_m0_rdata, s_m1_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Ownership rules: who is served next, given who owns now and who asks.
  task automatic model_advance();
    if (m_own == 0) begin
      if (m1_req && !m0_req) begin
        m_own = 1; m_wait = 0; m_hold = 0;
      end else if (m1_req) begin
        if (m_wait == MAX_WAIT - 1) begin m_own = 1; m_wait = 0; m_hold = 0; end
        else m_wait++;
      end else m_wait = 0;
    end else begin
      if (!m1_req || (m0_req && !m1_lock)) begin
        m_own = 0; m_wait = 0; m_hold = 0;
      end else if (m0_req) begin
        if (m_hold == MAX_HOLD - 1) begin m_own = 0; m_wait = 0; m_hold = 0; end
        else m_hold++;
      end
    end
  endtask

  // One clock: sample and check at the falling edge, advance the model,
  // then return just after the rising edge so the caller can drive inputs.
  task automatic cycle();
    logic ea0, ea1, ewe;
    logic [3:0] esel;
    logic [31:0] eaddr, edat, erd0, erd1;
    @(negedge clk);
    ea0 = 0; ea1 = 0; ewe = 0; esel = '0; eaddr = '0; edat = '0; erd0 = '0; erd1 = '0;
    if (rst) begin
      ea0 = (m_own == 0) && m0_req;
      ea1 = (m_own == 1) && m1_req;
      if (ea0) begin
        ewe = m0_we; esel = m0_sel; eaddr = m0_addr; edat = m0_wdata;
        erd0 = ref_mem[m0_addr[7:2]];
      end
      if (ea1) begin
        ewe = m1_we; esel = m1_sel; eaddr = m1_addr; edat = m1_wdata;
        erd1 = ref_mem[m1_addr[7:2]];
      end
    end
    s_m0_ack = m0_ack; s_m1_ack = m1_ack;
    s_m0_stall = m0_stall; s_m1_stall = m1_stall;
    s_m0_rdata = m0_rdata; s_m1_rdata = m1_rdata;
    check("m0_ack", 32'(m0_ack), 32'(ea0));
    check("m1_ack", 32'(m1_ack), 32'(ea1));
    check("m0_stall", 32'(m0_stall), 32'(rst & m0_req & ~ea0));
    check("m1_stall", 32'(m1_stall), 32'(rst & m1_req & ~ea1));
    check("m0_rdata", m0_rdata, erd0);
    check("m1_rdata", m1_rdata, erd1);
    check("ram_ce", 32'(ram_ce), 32'(ea0 | ea1));
    check("ram_we", 32'(ram_we), 32'(ewe));
    check("ram_sel", 32'(ram_sel), 32'(esel));
    check("ram_addr", ram_addr, eaddr);
    check("ram_data_o", ram_data_o, edat);
    if (!rst) begin
      m_own = 0; m_wait = 0; m_hold = 0;
    end else begin
      if (ewe)
        for (int b = 0; b < 4; b++)
          if (esel[b]) ref_mem[eaddr[7:2]][8*b +: 8] = edat[8*b +: 8];
      model_advance();
    end
    pend0 = rst && m0_req && !ea0;
    pend1 = rst && m1_req && !ea1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
  endtask

  initial begin
    int first1, first0, n1;
    logic m0_after;
    n_checks = 0; n_err = 0;
    m_own = 0; m_wait = 0; m_hold = 0;
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    // Reset with both masters trying to write.
    rst = 0;
    m0_req = 1; m0_we = 1; m0_sel = 4'hF; m0_addr = 32'h10; m0_wdata = 32'hAAAA5555;
    m1_req = 1; m1_we = 1; m1_sel = 4'hF; m1_addr = 32'h14; m1_wdata = 32'h5555AAAA;
    m1_lock = 1;
    repeat (3) cycle();
    check("rst_nowrite_m0", mem[4], 32'h0);
    check("rst_nowrite_m1", mem[5], 32'h0);
    rst = 1; m0_we = 0;
    cycle();
    check("rst_release_m0_ack", 32'(s_m0_ack), 32'd1);
    idle(); cycle();

    // M0 write then read back.
    m0_req = 1; m0_we = 1; m0_sel = 4'hF; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    cycle();
    check("m0_wr_stall", 32'(s_m0_stall), 32'd0);
    m0_we = 0;
    cycle();
    check("m0_rd_data", s_m0_rdata, 32'hDEADBEEF);
    check("m0_rd_stall", 32'(s_m0_stall), 32'd0);
    idle(); cycle();

    // Continuous contention, unlocked M1.
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h10; m1_lock = 0;
    first1 = 0; m0_after = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (s_m1_ack && first1 == 0) first1 = i;
      if (i == 6) m0_after = s_m0_ack;
    end
    check("cont_first_m1_ack", 32'(first1), 32'd5);
    check("cont_unlocked_yield", 32'(m0_after), 32'd1);
    idle(); cycle();

    // Locked M1 burst overridden by a waiting M0.
    m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 32'h10;
    cycle();
    check("lock_entry_stall", 32'(s_m1_stall), 32'd1);
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    n1 = 0; first0 = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (s_m1_ack && first0 == 0) n1++;
      if (s_m0_ack && first0 == 0) first0 = i;
    end
    check("lock_m1_ack_count", 32'(n1), 32'd8);
    check("lock_first_m0_ack", 32'(first0), 32'd9);
    idle(); cycle();

    // M1 alone writes, then M0 reads the word back after handover.
    m1_req = 1; m1_we = 1; m1_sel = 4'hF; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    cycle();
    check("m1_alone_stall", 32'(s_m1_stall), 32'd1);
    cycle();
    check("m1_alone_ack", 32'(s_m1_ack), 32'd1);
    m1_req = 0; m1_we = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    cycle();
    check("handover_m0_stall", 32'(s_m0_stall), 32'd1);
    cycle();
    check("handover_m0_rdata", s_m0_rdata, 32'h12345678);
    idle(); cycle();

    // Reset in the middle of a locked M1 write burst.
    m1_req = 1; m1_lock = 1; m1_we = 1; m1_sel = 4'hF; m1_addr = 32'h30; m1_wdata = 32'h11111111;
    cycle();
    cycle();
    m1_wdata = 32'h22222222; rst = 0;
    cycle();
    check("rst_abort_mem", mem[12], 32'h11111111);
    rst = 1; m1_we = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h30;
    first1 = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 1) check("rst_mid_g0_ack", 32'(s_m0_ack), 32'd1);
      if (s_m1_ack && first1 == 0) first1 = i;
    end
    check("rst_mid_counters_clear", 32'(first1), 32'd5);
    idle(); cycle();

    // Randomized traffic; a stalled master keeps its request stable.
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      if (!pend0) begin
        m0_req = ($urandom_range(0, 9) < 7);
        m0_we = 1'($urandom);
        m0_sel = 4'($urandom);
        m0_addr = {24'd0, 6'($urandom), 2'b00};
        m0_wdata = $urandom;
      end
      if (!pend1) begin
        m1_req = ($urandom_range(0, 9) < 6);
        m1_we = 1'($urandom);
        m1_sel = 4'($urandom);
        m1_addr = {24'd0, 6'($urandom), 2'b00};
        m1_wdata = $urandom;
      end
      m1_lock = 1'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
